match_sequencer: RTL and testbench
==================================

# match_sequencer

Match-level sequencer for the ball-and-paddle game. It owns the point/serve/game-over flow and the score registers, and gates the ball engine through `ball_enable` and `serve_req`. The ball engine reports wall misses as `point_p1` / `point_p2` pulses. The sequencer decides who serves, when play resumes (auto or manual), and when the match ends.

## Interface
Parameters:
- `WIN_SCORE`, default 15: score that ends the match. Legal range 1..31.
- `AUTO_DELAY`, default 120: number of `tick` pulses waited before an auto serve. Legal range 1..255.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `tick`, input, 1: one-cycle frame pulse (about 60 Hz).
- `mode`, input, 2: game mode. 00 tennis, 01 soccer, 10 squash, 11 practice.
- `serve_type`, input, 1: 0 auto, 1 manual.
- `serve`, input, 1: raw serve button. Asynchronous, level.
- `point_p1`, input, 1: one-cycle pulse, player 1 won the rally.
- `point_p2`, input, 1: one-cycle pulse, player 2 won the rally.
- `ball_enable`, output, 1: ball engine may move the ball.
- `serve_req`, output, 1: one-cycle pulse telling the ball engine to launch from `server`'s side.
- `server`, output, 1: 0 = player 1 serves, 1 = player 2 serves.
- `p1_score`, output, 5: player 1 score.
- `p2_score`, output, 5: player 2 score.
- `game_over`, output, 1: match finished.
- `winner`, output, 1: 0 = player 1, 1 = player 2. Valid only while `game_over` is high.
- `state`, output, 2: current FSM state, for debug and display.

## Operation
The FSM has four states: IDLE=0, SERVE_WAIT=1, PLAY=2, OVER=3.

Serve edge (`serve_edge`):
- `serve` passes through a 2-flop synchronizer.
- A rising-edge detect produces a one-cycle `serve_edge`.

IDLE (reset state):
- Ball frozen.
- `serve_edge` moves to SERVE_WAIT with the wait counter loaded to `AUTO_DELAY`.

SERVE_WAIT:
- `ball_enable` is 0.
- Manual mode (`serve_type`=1): `serve_edge` launches.
- Auto mode: the counter decrements on each `tick` and launches when it reaches 0. A `serve_edge` in auto mode launches immediately.
- `serve_type` is sampled every cycle. Switching mode mid-wait keeps the current counter value.
- On launch: assert `serve_req` for one cycle and go to PLAY.

PLAY:
- `ball_enable` is 1.
- A lone `point_p1` adds 1 to `p1_score`. A lone `point_p2` adds 1 to `p2_score`. Then go to OVER if the match ends, otherwise go to SERVE_WAIT and reload the counter.
- `point_p1` and `point_p2` in the same cycle is a let: no score change, same server, go to SERVE_WAIT.

Match end:
- Tennis, soccer and squash: the updated score equals `WIN_SCORE`. Set `winner` to the scorer.
- Practice: the match never ends. Scores saturate at 31.

Server selection, applied on each scored point:
- Tennis: `server` toggles after every 2nd total point, i.e. when the new (`p1_score`+`p2_score`) is even. Width is 6 bits.
- Soccer: the conceding player serves.
- Squash and practice: the point winner serves.
- A let leaves `server` unchanged.

OVER:
- `game_over` is 1 and `ball_enable` is 0. Scores and `winner` are held.
- `serve_edge` clears both scores and `server`, deasserts `game_over`, reloads the counter, and goes to SERVE_WAIT.

Ignored inputs:
- Point pulses outside PLAY are ignored.
- `serve_edge` in PLAY is ignored.

A change on `mode` takes effect at the next point evaluation. Scores are not cleared.

## Timing
- Every output is registered.
- Reset values: `ball_enable`=0, `serve_req`=0, `server`=0, both scores=0, `game_over`=0, `winner`=0, `state`=IDLE, wait counter=0, synchronizer=0.
- Button to `serve_edge`: 2 cycles. `serve_edge` to `serve_req`: 1 cycle. `ball_enable` rises in the same cycle as `serve_req`.
- Point pulse in cycle N: scores, `server`, `state`, `game_over` and `winner` all update at edge N+1. `ball_enable` is 0 from cycle N+1.
- Auto serve: `serve_req` is asserted the cycle after the `AUTO_DELAY`-th `tick` following entry to SERVE_WAIT.
- A `tick` coinciding with `serve_edge`: the edge wins, and only a single `serve_req` is issued.
- Reset asserted mid-operation clears everything immediately and asynchronously. A `serve_req` in flight is dropped.

## Structure
- Shared package `game_pkg` holds:
  - The state enum (IDLE, SERVE_WAIT, PLAY, OVER).
  - The mode encodings (MODE_TENNIS=2'b00, MODE_SOCCER=2'b01, MODE_SQUASH=2'b10, MODE_PRACTICE=2'b11).
  - The score width constant `SCORE_W`=5.
- One sub-module, `button_sync`: 2-flop synchronizer plus rising-edge pulse. It is reused later for the paddle and option buttons.

## Test plan
- Reset, then manual serve: button high for 10 cycles produces exactly one `serve_req`, 3 cycles after the button rises. State goes IDLE→SERVE_WAIT→PLAY. `ball_enable`=1.
- Auto serve with `AUTO_DELAY`=3: after a point, `serve_req` arrives the cycle after the 3rd `tick`. Pressing `serve` after the 1st `tick` serves immediately instead.
- Tennis server rotation: points p1, p1, p2, p2 give `server` sequence 0, 1, 1, 0 after each point. Soccer: a `point_p1` makes `server`=1.
- Win with `WIN_SCORE`=3: p1 scores 3 points, giving `game_over`=1, `winner`=0, `p1_score`=3. Further points are ignored. `serve` clears the scores and returns to SERVE_WAIT.
- Simultaneous `point_p1` and `point_p2` in PLAY: scores unchanged, `server` unchanged, state becomes SERVE_WAIT. Point pulses in SERVE_WAIT are ignored.
- Practice mode: 40 `point_p1` pulses leave `p1_score` saturated at 31 with `game_over`=0. Asserting `rst` mid-PLAY clears all outputs asynchronously.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the ball-and-paddle game blocks: FSM state encoding,
// game mode encodings, score width and a saturating score increment.
package game_pkg;

  localparam int SCORE_W = 5;

  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_WAIT = 2'd1,
    PLAY       = 2'd2,
    OVER       = 2'd3
  } state_t;

  localparam logic [1:0] MODE_TENNIS   = 2'b00;
  localparam logic [1:0] MODE_SOCCER   = 2'b01;
  localparam logic [1:0] MODE_SQUASH   = 2'b10;
  localparam logic [1:0] MODE_PRACTICE = 2'b11;

  // Scores stop at the all-ones value instead of wrapping.
  function automatic score_t sat_inc(input score_t s);
    return (s == '1) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for an asynchronous level input followed by a
// rising-edge detector producing a one-cycle pulse.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   din   - raw asynchronous button level
//   pulse - one-cycle pulse, high in the cycle after the synchronized rise
module button_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  // [0] and [1] form the synchronizer, [2] holds the previous synced level.
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], din};
  end

  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/match_sequencer.sv
// Match-level sequencer: owns serve/point/game-over flow and the scores, and
// gates the ball engine through ball_enable and serve_req.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   tick                - one-cycle frame pulse, paces the auto-serve delay
//   mode                - 00 tennis, 01 soccer, 10 squash, 11 practice
//   serve_type          - 0 auto serve, 1 manual serve
//   serve               - raw serve button (asynchronous level)
//   point_p1, point_p2  - rally-won pulses from the ball engine
//   ball_enable         - ball may move
//   serve_req           - one-cycle launch pulse from server's side
//   server              - 0 player 1 serves, 1 player 2 serves
//   p1_score, p2_score  - scores
//   game_over, winner   - match finished / who won (valid with game_over)
//   state               - current FSM state
//
// state      | meaning
// IDLE       | after reset, ball frozen, waiting for first serve press
// SERVE_WAIT | ball frozen, waiting for serve press or auto-serve delay
// PLAY       | ball moving, waiting for a point report
// OVER       | match decided, scores held until serve press restarts
module match_sequencer
  import game_pkg::*;
#(
  parameter int WIN_SCORE  = 15,
  parameter int AUTO_DELAY = 120
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [1:0]         mode,
  input  logic               serve_type,
  input  logic               serve,
  input  logic               point_p1,
  input  logic               point_p2,
  output logic               ball_enable,
  output logic               serve_req,
  output logic               server,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               game_over,
  output logic               winner,
  output logic [1:0]         state
);

  localparam logic [7:0] DELAY_LOAD = 8'(AUTO_DELAY);
  localparam score_t     WIN_VAL    = score_t'(WIN_SCORE);

  logic       serve_edge;
  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  score_t     p1_d, p2_d, p1_inc, p2_inc;
  logic       server_d, game_over_d, winner_d, serve_req_d, ball_enable_d;
  logic       launch, scorer, win_hit;

  button_sync u_serve_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (serve),
    .pulse (serve_edge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      p1_score    <= '0;
      p2_score    <= '0;
      server      <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      serve_req   <= 1'b0;
      ball_enable <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      p1_score    <= p1_d;
      p2_score    <= p2_d;
      server      <= server_d;
      game_over   <= game_over_d;
      winner      <= winner_d;
      serve_req   <= serve_req_d;
      ball_enable <= ball_enable_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    p1_d        = p1_score;
    p2_d        = p2_score;
    server_d    = server;
    game_over_d = game_over;
    winner_d    = winner;
    serve_req_d = 1'b0;
    launch      = 1'b0;
    win_hit     = 1'b0;
    scorer      = point_p2;
    p1_inc      = sat_inc(p1_score);
    p2_inc      = sat_inc(p2_score);

    case (state_q)
      IDLE: begin
        if (serve_edge) begin
          state_d    = SERVE_WAIT;
          wait_cnt_d = DELAY_LOAD;
        end
      end

      SERVE_WAIT: begin
        // The counter only moves in auto mode, so toggling serve_type
        // mid-wait resumes from where it stopped.
        if (!serve_type && tick) begin
          wait_cnt_d = (wait_cnt_q == '0) ? '0 : wait_cnt_q - 8'd1;
          launch     = (wait_cnt_q <= 8'd1);
        end
        if (serve_edge) launch = 1'b1;
        if (launch) begin
          serve_req_d = 1'b1;
          state_d     = PLAY;
        end
      end

      PLAY: begin
        if (point_p1 && point_p2) begin
          state_d    = SERVE_WAIT;
          wait_cnt_d = DELAY_LOAD;
        end else if (point_p1 || point_p2) begin
          if (point_p1) p1_d = p1_inc;
          else          p2_d = p2_inc;
          case (mode)
            // New total is even exactly when both LSBs agree.
            MODE_TENNIS: if (p1_d[0] == p2_d[0]) server_d = ~server;
            MODE_SOCCER: server_d = ~scorer;
            default:     server_d = scorer;
          endcase
          win_hit = (mode != MODE_PRACTICE) &&
                    ((scorer ? p2_d : p1_d) == WIN_VAL);
          if (win_hit) begin
            state_d     = OVER;
            game_over_d = 1'b1;
            winner_d    = scorer;
          end else begin
            state_d    = SERVE_WAIT;
            wait_cnt_d = DELAY_LOAD;
          end
        end
      end

      OVER: begin
        if (serve_edge) begin
          p1_d        = '0;
          p2_d        = '0;
          server_d    = 1'b0;
          game_over_d = 1'b0;
          wait_cnt_d  = DELAY_LOAD;
          state_d     = SERVE_WAIT;
        end
      end

      default: state_d = IDLE;
    endcase

    ball_enable_d = (state_d == PLAY);
  end

  assign state = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
module tb_match_sequencer;
  import game_pkg::*;

  localparam int WIN = 3;
  localparam int DLY = 3;

  logic       clk = 1'b0;
  logic       rst, tick, serve_type, serve, point_p1, point_p2;
  logic [1:0] mode;
  logic       ball_enable, serve_req, server, game_over, winner;
  logic [4:0] p1_score, p2_score;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;
  int n_req = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  match_sequencer #(.WIN_SCORE(WIN), .AUTO_DELAY(DLY)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .mode       (mode),
    .serve_type (serve_type),
    .serve      (serve),
    .point_p1   (point_p1),
    .point_p2   (point_p2),
    .ball_enable(ball_enable),
    .serve_req  (serve_req),
    .server     (server),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .game_over  (game_over),
    .winner     (winner),
    .state      (state)
  );

  // Game-level model: phase numbers are the documented state values,
  // scores are plain integers, auto delay counts ticks upward.
  typedef struct packed {
    int phase;
    int s1;
    int s2;
    int ticks;
    bit srv;
    bit go;
    bit win;
    bit req;
    bit ben;
    bit h0;
    bit h1;
    bit h2;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t c, logic sv, logic tk, logic st,
                                        logic [1:0] md, logic a, logic b);
    model_t n;
    logic sedge;
    logic w;
    n = c;
    sedge = c.h1 && !c.h2;
    n.h0 = sv;
    n.h1 = c.h0;
    n.h2 = c.h1;
    n.req = 1'b0;
    case (c.phase)
      0: if (sedge) begin n.phase = 1; n.ticks = 0; end
      1: begin
        if (!st && tk) n.ticks = c.ticks + 1;
        if (sedge || (!st && tk && n.ticks >= DLY)) begin
          n.phase = 2;
          n.req = 1'b1;
        end
      end
      2: begin
        if (a && b) begin
          n.phase = 1;
          n.ticks = 0;
        end else if (a || b) begin
          w = b;
          if (a) n.s1 = (c.s1 >= 31) ? 31 : c.s1 + 1;
          else   n.s2 = (c.s2 >= 31) ? 31 : c.s2 + 1;
          if (md == MODE_TENNIS) begin
            if ((n.s1 + n.s2) % 2 == 0) n.srv = !c.srv;
          end else if (md == MODE_SOCCER) begin
            n.srv = !w;
          end else begin
            n.srv = w;
          end
          if (md != MODE_PRACTICE && (w ? n.s2 : n.s1) == WIN) begin
            n.phase = 3;
            n.go = 1'b1;
            n.win = w;
          end else begin
            n.phase = 1;
            n.ticks = 0;
          end
        end
      end
      default: if (sedge) begin
        n.s1 = 0;
        n.s2 = 0;
        n.srv = 1'b0;
        n.go = 1'b0;
        n.phase = 1;
        n.ticks = 0;
      end
    endcase
    n.ben = (n.phase == 2);
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_step(m, serve, tick, serve_type, mode, point_p1, point_p2);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("m_state",     int'(state),       m.phase);
      check("m_ball_en",   int'(ball_enable), int'(m.ben));
      check("m_serve_req", int'(serve_req),   int'(m.req));
      check("m_server",    int'(server),      int'(m.srv));
      check("m_p1_score",  int'(p1_score),    m.s1);
      check("m_p2_score",  int'(p2_score),    m.s2);
      check("m_game_over", int'(game_over),   int'(m.go));
      if (m.go) check("m_winner", int'(winner), int'(m.win));
      if (serve_req) n_req++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    serve = 1'b1;
    step();
    step();
    serve = 1'b0;
    repeat (4) step();
  endtask

  task automatic point(input logic a, input logic b);
    point_p1 = a;
    point_p2 = b;
    step();
    point_p1 = 1'b0;
    point_p2 = 1'b0;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  initial begin
    int req0;
    int first_k;
    rst = 1'b1;
    tick = 1'b0;
    serve = 1'b0;
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    serve_type = 1'b1;
    mode = MODE_TENNIS;

    #12;
    check("rst_state",     int'(state),       0);
    check("rst_ball_en",   int'(ball_enable), 0);
    check("rst_serve_req", int'(serve_req),   0);
    check("rst_scores",    int'(p1_score) + int'(p2_score), 0);
    check("rst_game_over", int'(game_over),   0);
    check("rst_server",    int'(server),      0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    step();
    step();

    // First press leaves IDLE; manual mode then needs its own press.
    press();
    check("idle_to_wait", int'(state), 1);
    check("idle_no_req",  n_req, 0);

    req0 = n_req;
    first_k = -1;
    serve = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (serve_req && first_k < 0) first_k = k;
    end
    serve = 1'b0;
    repeat (4) step();
    check("manual_latency", first_k, 3);
    check("manual_single",  n_req - req0, 1);
    check("manual_play",    int'(state), 2);
    check("manual_ball_en", int'(ball_enable), 1);

    // Tennis rotation p1, p1, p2, p2 -> 0, 1, 1, 0
    point(1, 0); check("tennis_1", int'(server), 0);
    press(); point(1, 0); check("tennis_2", int'(server), 1);
    press(); point(0, 1); check("tennis_3", int'(server), 1);
    press(); point(0, 1); check("tennis_4", int'(server), 0);
    check("tennis_score", int'(p1_score) * 100 + int'(p2_score), 202);

    // Let, then ignored point in SERVE_WAIT
    press(); point(1, 1);
    check("let_state",  int'(state), 1);
    check("let_server", int'(server), 0);
    check("let_score",  int'(p1_score) * 100 + int'(p2_score), 202);
    point(1, 0);
    check("wait_ignore", int'(p1_score), 2);

    // Soccer point by p1 also reaches WIN_SCORE
    mode = MODE_SOCCER;
    press(); point(1, 0);
    check("soccer_server", int'(server), 1);
    check("soccer_over",   int'(game_over), 1);
    check("soccer_winner", int'(winner), 0);
    check("soccer_p1",     int'(p1_score), 3);
    point(0, 1);
    check("over_ignore",   int'(p2_score), 2);
    press();
    check("clear_state", int'(state), 1);
    check("clear_score", int'(p1_score) + int'(p2_score), 0);
    check("clear_over",  int'(game_over), 0);

    // Squash: p1 wins 3-0
    mode = MODE_SQUASH;
    repeat (3) begin
      press();
      point(1, 0);
    end
    check("win_over",   int'(game_over), 1);
    check("win_winner", int'(winner), 0);
    check("win_p1",     int'(p1_score), 3);
    press();

    // Auto serve after the third tick
    serve_type = 1'b0;
    tick_pulse();
    tick_pulse();
    check("auto_wait", int'(serve_req) * 10 + int'(state), 1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("auto_tick3", int'(serve_req), 1);
    step();
    point(0, 1);
    check("squash_server", int'(server), 1);

    // Manual interlude freezes the count
    tick_pulse();
    serve_type = 1'b1;
    tick_pulse();
    tick_pulse();
    serve_type = 1'b0;
    tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("auto_resume", int'(serve_req), 1);
    step();
    point(0, 1);

    // Press after first tick, tick coinciding with the edge
    tick_pulse();
    req0 = n_req;
    serve = 1'b1;
    step();
    step();
    serve = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("edge_wins", int'(serve_req), 1);
    repeat (4) step();
    check("edge_single", n_req - req0, 1);

    // Practice saturation
    serve_type = 1'b1;
    mode = MODE_PRACTICE;
    repeat (40) begin
      point(1, 0);
      press();
    end
    check("prac_p1",   int'(p1_score), 31);
    check("prac_over", int'(game_over), 0);

    // Reset while a serve_req is in flight
    point(1, 0);
    serve = 1'b1;
    step();
    step();
    serve = 1'b0;
    step();
    check("pre_rst_req", int'(serve_req), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req",    int'(serve_req),   0);
    check("arst_ball",   int'(ball_enable), 0);
    check("arst_state",  int'(state),       0);
    check("arst_p1",     int'(p1_score),    0);
    check("arst_server", int'(server),      0);
    check("arst_winner", int'(winner),      0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();
    check("post_rst_state", int'(state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
